// File: rtl/mp_add_seq_if.sv
// Operand and result word streams between the requester/consumer and mp_add_seq.
// The slave modport is the sequencer side; master is the requester/consumer side.
interface mp_add_seq_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_s;
  logic              out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_s, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_s, out_last
  );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams NWORDS word pairs, LS word first,
// through one external 16-bit adder and chains the carry between passes in a register.
module mp_add_seq #(
  parameter int NWORDS  = 4,
  parameter int CNT_W   = 4,
  parameter int ADD_LAT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        sub,
  output logic        busy,
  mp_add_seq_if.slave io,
  output logic        carry_out,
  output logic        ovf,
  output logic        done,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout
);
  localparam int DATA_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                sub_r;
  logic                carry_r;
  logic                last_issued;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   add_a_p0, add_b_p0;
  logic                add_cin_p0;
  logic [DATA_W-1:0]   out_s_p1;
  logic                out_last_p1;
  logic                vld_p1;
  logic                in_ready_c;
  logic                accept;
  logic                capture;
  logic                cap_last;
  logic                out_pop;

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    in_ready_c = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        in_ready_c = !vld_p1 || io.out_ready;
        if (in_ready_c && io.in_valid) begin
          if (ADD_LAT != 0)          state_nxt = S_WAIT;
          else if (cnt == LAST_CNT)  state_nxt = S_DRAIN;
        end
      end
      S_WAIT:  state_nxt = last_issued ? S_DRAIN : S_RUN;
      S_DRAIN: if (vld_p1 && io.out_ready && out_last_p1) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept   = io.in_valid && in_ready_c;
  assign out_pop  = vld_p1 && io.out_ready;
  // A combinational adder is sampled on the issue edge; a registered one one edge later in WAIT.
  assign capture  = (ADD_LAT == 0) ? accept : (state == S_WAIT);
  assign cap_last = (ADD_LAT == 0) ? (cnt == LAST_CNT) : last_issued;

  // Issue stage: the adder sees the new word during the accept cycle, then the held copy.
  assign add_a   = accept ? io.in_a : add_a_p0;
  assign add_b   = accept ? (io.in_b ^ {DATA_W{sub_r}}) : add_b_p0;
  assign add_cin = accept ? carry_r : add_cin_p0;

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = vld_p1;
  assign io.out_s     = out_s_p1;
  assign io.out_last  = out_last_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      last_issued <= 1'b0;
      cnt         <= '0;
      add_a_p0    <= '0;
      add_b_p0    <= '0;
      add_cin_p0  <= 1'b0;
      out_s_p1    <= '0;
      out_last_p1 <= 1'b0;
      vld_p1      <= 1'b0;
      carry_out   <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        sub_r       <= sub;
        carry_r     <= sub;
        cnt         <= '0;
        last_issued <= 1'b0;
        carry_out   <= 1'b0;
        ovf         <= 1'b0;
      end
      if (accept) begin
        add_a_p0   <= add_a;
        add_b_p0   <= add_b;
        add_cin_p0 <= add_cin;
        if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
        else                 last_issued <= 1'b1;
      end
      // Result stage: single-entry output buffer, also the carry chain register.
      if (capture) begin
        out_s_p1    <= add_s;
        out_last_p1 <= cap_last;
        vld_p1      <= 1'b1;
        carry_r     <= add_cout;
        if (cap_last) begin
          carry_out <= add_cout;
          ovf       <= (add_a[DATA_W-1] == add_b[DATA_W-1]) && (add_s[DATA_W-1] != add_a[DATA_W-1]);
        end
      end else if (out_pop) begin
        vld_p1 <= 1'b0;
      end
    end
  end
endmodule
